// File: rtl/hack_bus_pkg.sv
// Shared definitions for the hack bus fan-out/fan-in blocks, so that the
// demux and the arbitrating mux agree on select-code widths.
package hack_bus_pkg;

  localparam int MAX_CHANNELS = 16;

  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter_np.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping
// from N-1 to 0. ptr moves past the winner only when the caller reports a transfer.
module rr_arbiter_np
  import hack_bus_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [N-1:0]        i_req,
  input  logic                i_advance,
  output logic [N-1:0]        o_grant,
  output logic [sel_w(N)-1:0] o_grant_idx
);

  localparam int W = sel_w(N);
  localparam logic [W-1:0] LAST_IDX = W'(N - 1);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;
  logic [W-1:0] idx_s;
  logic [W-1:0] cand_s;
  logic         found_s;

  // Wrap-around search; candidate indices are folded so they never reach N.
  always_comb begin
    int cand;
    found_s = 1'b0;
    idx_s   = '0;
    cand_s  = '0;
    cand    = 0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= N) begin
        cand = cand - N;
      end else begin
        cand = cand;
      end
      cand_s = W'(cand);
      if (!found_s && i_req[cand_s]) begin
        found_s = 1'b1;
        idx_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign o_grant     = found_s ? (N'(1) << idx_s) : '0;
  assign o_grant_idx = idx_s;

  // Pointer steps past the winner only on an accepted transfer.
  always_comb begin
    ptr_d = ptr_q;
    if (i_advance) begin
      ptr_d = (idx_s == LAST_IDX) ? '0 : idx_s + W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mux_arb_np.sv
// N-to-1 round-robin merge of valid/ready source channels into one registered
// output stream that carries the index of the winning source.
module mux_arb_np
  import hack_bus_pkg::*;
#(
  parameter int N = 2,
  parameter int D = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [N-1:0]        i_valid,
  input  logic [D-1:0]        i_data [N-1:0],
  output logic [N-1:0]        o_ready,
  output logic                o_valid,
  output logic [D-1:0]        o_data,
  output logic [sel_w(N)-1:0] o_sel,
  input  logic                i_ready
);

  localparam int W = sel_w(N);

  logic [N-1:0] grant_s;
  logic [W-1:0] grant_idx_s;
  logic         free_s;
  logic         advance_s;

  logic         valid_q;
  logic         valid_d;
  logic [D-1:0] data_q;
  logic [D-1:0] data_d;
  logic [W-1:0] sel_q;
  logic [W-1:0] sel_d;

  rr_arbiter_np #(
    .N(N)
  ) u_arb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_req      (i_valid),
    .i_advance  (advance_s),
    .o_grant    (grant_s),
    .o_grant_idx(grant_idx_s)
  );

  // The register can take a word when empty or when it drains this same cycle.
  always_comb begin
    free_s    = !valid_q || i_ready;
    o_ready   = (free_s && !i_rst) ? grant_s : '0;
    advance_s = |o_ready;
  end

  // Output register next state: load, drain, or hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (advance_s) begin
      valid_d = 1'b1;
      data_d  = i_data[grant_idx_s];
      sel_d   = grant_idx_s;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output register; reset discards any held word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_sel   = sel_q;

endmodule

// File: tb/tb_mux_arb_np.sv
// Bench for mux_arb_np: an N=2 and an N=3 instance, directed scenarios plus
// random traffic, checked against a queue-free round-robin reference model.
module tb_mux_arb_np;

  logic clk = 1'b0;
  logic rst;

  logic [1:0]  v2;
  logic [15:0] dat2 [1:0];
  logic        rdy2;
  logic [1:0]  o_ready2;
  logic        o_valid2;
  logic [15:0] o_data2;
  logic [0:0]  o_sel2;

  logic [2:0]  v3;
  logic [15:0] dat3 [2:0];
  logic        rdy3;
  logic [2:0]  o_ready3;
  logic        o_valid3;
  logic [15:0] o_data3;
  logic [1:0]  o_sel3;

  int checks = 0;
  int errors = 0;

  // Reference state per instance (index 0: N=2, index 1: N=3).
  int          m_ptr   [2];
  bit          m_valid [2];
  logic [15:0] m_data  [2];
  int          m_sel   [2];
  logic [2:0]  last_ready;

  always #5 clk = ~clk;

  mux_arb_np #(.N(2), .D(16)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(v2), .i_data(dat2), .o_ready(o_ready2),
    .o_valid(o_valid2), .o_data(o_data2), .o_sel(o_sel2), .i_ready(rdy2)
  );

  mux_arb_np #(.N(3), .D(16)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_valid(v3), .i_data(dat3), .o_ready(o_ready3),
    .o_valid(o_valid3), .o_data(o_data3), .o_sel(o_sel3), .i_ready(rdy3)
  );

  function automatic int rr_pick(input int n, input int ptr, input logic [2:0] v);
    for (int i = 0; i < n; i++) begin
      int c;
      c = (ptr + i) % n;
      if (((v >> c) & 3'b001) != 3'b000) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ptr[i] = 0; m_valid[i] = 1'b0; m_data[i] = 16'h0000; m_sel[i] = 0;
    end
  endtask

  // One clock cycle on one instance (the other is kept idle), checked against the model.
  task automatic cyc(input int inst, input logic [2:0] v, input logic [15:0] a,
                     input logic [15:0] b, input logic [15:0] c, input logic rdy,
                     input string tag);
    int n; int w; bit fr; bit orr;
    logic [2:0] vm; logic [2:0] exp_rdy; logic [2:0] got_rdy;
    logic [15:0] dw [3];
    logic ov; logic [15:0] od; int os;
    n = (inst == 0) ? 2 : 3;
    vm = (inst == 0) ? (v & 3'b011) : v;
    dw[0] = a; dw[1] = b; dw[2] = c;
    if (inst == 0) begin
      v2 = vm[1:0]; dat2[0] = a; dat2[1] = b; rdy2 = rdy; v3 = 3'b000; orr = rdy3;
    end else begin
      v3 = vm; dat3[0] = a; dat3[1] = b; dat3[2] = c; rdy3 = rdy; v2 = 2'b00; orr = rdy2;
    end
    #1;
    got_rdy = (inst == 0) ? {1'b0, o_ready2} : o_ready3;
    fr = !m_valid[inst] || rdy;
    w = rr_pick(n, m_ptr[inst], vm);
    exp_rdy = (fr && w >= 0) ? (3'b001 << w) : 3'b000;
    checks++;
    if (got_rdy !== exp_rdy) begin
      errors++;
      $display("FAIL %s o_ready got %b expected %b", tag, got_rdy, exp_rdy);
    end
    last_ready = got_rdy;
    if (fr && w >= 0) begin
      m_valid[inst] = 1'b1; m_data[inst] = dw[w]; m_sel[inst] = w; m_ptr[inst] = (w + 1) % n;
    end else if (m_valid[inst] && rdy) begin
      m_valid[inst] = 1'b0;
    end
    if (m_valid[1-inst] && orr) m_valid[1-inst] = 1'b0;
    @(posedge clk); #1;
    if (inst == 0) begin
      ov = o_valid2; od = o_data2; os = int'(o_sel2);
    end else begin
      ov = o_valid3; od = o_data3; os = int'(o_sel3);
    end
    checks++;
    if (ov !== m_valid[inst]) begin
      errors++; $display("FAIL %s o_valid got %b expected %b", tag, ov, m_valid[inst]);
    end
    checks++;
    if (od !== m_data[inst]) begin
      errors++; $display("FAIL %s o_data got %h expected %h", tag, od, m_data[inst]);
    end
    checks++;
    if (os !== m_sel[inst]) begin
      errors++; $display("FAIL %s o_sel got %0d expected %0d", tag, os, m_sel[inst]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; v2 = 2'b11; v3 = 3'b111; rdy2 = 1'b1; rdy3 = 1'b1;
    #2;
    checks++;
    if ({o_valid2, o_data2, o_sel2, o_ready2} !== 20'h00000) begin
      errors++; $display("FAIL reset_n2 got v=%b d=%h s=%b r=%b expected all zero",
                         o_valid2, o_data2, o_sel2, o_ready2);
    end
    checks++;
    if ({o_valid3, o_data3, o_sel3, o_ready3} !== 22'h000000) begin
      errors++; $display("FAIL reset_n3 got v=%b d=%h s=%b r=%b expected all zero",
                         o_valid3, o_data3, o_sel3, o_ready3);
    end
    @(posedge clk); #1;
    rst = 1'b0; v2 = 2'b00; v3 = 3'b000;
    model_reset();
    cyc(0, 3'b010, 16'h1111, 16'h5A5A, 16'h0000, 1'b0, "rst_load");
    cyc(0, 3'b011, 16'h1111, 16'h5A5A, 16'h0000, 1'b0, "rst_stall");
    rdy2 = 1'b1; rst = 1'b1;
    #1;
    checks++;
    if ({o_valid2, o_data2, o_sel2, o_ready2} !== 20'h00000) begin
      errors++; $display("FAIL reset_async got v=%b d=%h s=%b r=%b expected all zero",
                         o_valid2, o_data2, o_sel2, o_ready2);
    end
    @(posedge clk); #1;
    checks++;
    if ({o_valid2, o_ready2} !== 3'b000) begin
      errors++; $display("FAIL reset_held got v=%b r=%b expected 0 00", o_valid2, o_ready2);
    end
    rst = 1'b0; v2 = 2'b00; v3 = 3'b000;
    model_reset();
  endtask

  task automatic test_single_source();
    for (int k = 0; k < 3; k++) begin
      cyc(0, 3'b001, 16'h1234, 16'hFFFF, 16'h0000, 1'b1, "single");
      checks++;
      if (last_ready[1] !== 1'b0) begin
        errors++; $display("FAIL single_ready1 got %b expected 0", last_ready[1]);
      end
      checks++;
      if (o_valid2 !== 1'b1 || o_data2 !== 16'h1234 || o_sel2 !== 1'b0) begin
        errors++; $display("FAIL single_word got v=%b d=%h s=%b expected 1 1234 0",
                           o_valid2, o_data2, o_sel2);
      end
    end
    cyc(0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b1, "single_drain");
  endtask

  task automatic test_round_robin();
    int cnt [3];
    cnt = '{0, 0, 0};
    for (int k = 0; k < 6; k++) begin
      cyc(1, 3'b111, 16'hA000, 16'hA001, 16'hA002, 1'b1, "rr");
      for (int j = 0; j < 3; j++) begin
        if (((last_ready >> j) & 3'b001) != 3'b000) cnt[j]++;
      end
      checks++;
      if (int'(o_sel3) !== k % 3 || o_data3 !== 16'hA000 + 16'(k % 3)) begin
        errors++; $display("FAIL rr_order step %0d got sel=%0d d=%h expected sel=%0d",
                           k, o_sel3, o_data3, k % 3);
      end
    end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (cnt[j] !== 2) begin
        errors++; $display("FAIL rr_fair ch%0d got %0d grants expected 2", j, cnt[j]);
      end
    end
  endtask

  task automatic test_wrap_idle();
    for (int k = 0; k < 5; k++) begin
      cyc(1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b1, "idle");
    end
    cyc(1, 3'b011, 16'hC000, 16'hC001, 16'hC002, 1'b1, "wrap0");
    checks++;
    if (o_sel3 !== 2'd0 || o_data3 !== 16'hC000) begin
      errors++; $display("FAIL wrap_first got sel=%0d d=%h expected 0 c000", o_sel3, o_data3);
    end
    cyc(1, 3'b011, 16'hC000, 16'hC001, 16'hC002, 1'b1, "wrap1");
    checks++;
    if (o_sel3 !== 2'd1 || o_data3 !== 16'hC001) begin
      errors++; $display("FAIL wrap_second got sel=%0d d=%h expected 1 c001", o_sel3, o_data3);
    end
    cyc(1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b1, "wrap_drain");
  endtask

  task automatic test_backpressure();
    cyc(0, 3'b010, 16'h0000, 16'hBEEF, 16'h0000, 1'b1, "bp_pre");
    cyc(0, 3'b011, 16'hB000, 16'hB001, 16'h0000, 1'b1, "bp_first");
    for (int k = 0; k < 4; k++) begin
      cyc(0, 3'b011, 16'hB000, 16'hB001, 16'h0000, 1'b0, "bp_stall");
      checks++;
      if (last_ready !== 3'b000 || o_valid2 !== 1'b1 || o_data2 !== 16'hB000 || o_sel2 !== 1'b0) begin
        errors++; $display("FAIL bp_frozen got r=%b v=%b d=%h s=%b expected 000 1 b000 0",
                           last_ready, o_valid2, o_data2, o_sel2);
      end
    end
    cyc(0, 3'b011, 16'hB000, 16'hB001, 16'h0000, 1'b1, "bp_release");
    checks++;
    if (o_sel2 !== 1'b1 || o_data2 !== 16'hB001) begin
      errors++; $display("FAIL bp_next got sel=%b d=%h expected 1 b001", o_sel2, o_data2);
    end
    cyc(0, 3'b001, 16'hB002, 16'h0000, 16'h0000, 1'b1, "bp_after");
    checks++;
    if (o_sel2 !== 1'b0 || o_data2 !== 16'hB002) begin
      errors++; $display("FAIL bp_after got sel=%b d=%h expected 0 b002", o_sel2, o_data2);
    end
    cyc(0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b1, "bp_drain");
    checks++;
    if (o_valid2 !== 1'b0 || o_data2 !== 16'hB002) begin
      errors++; $display("FAIL bp_drain_hold got v=%b d=%h expected 0 b002", o_valid2, o_data2);
    end
  endtask

  task automatic test_drain_refill();
    cyc(0, 3'b001, 16'hD000, 16'h0000, 16'h0000, 1'b1, "dr_load");
    cyc(0, 3'b010, 16'hD000, 16'hD001, 16'h0000, 1'b1, "dr_refill");
    checks++;
    if (last_ready !== 3'b010 || o_valid2 !== 1'b1 || o_data2 !== 16'hD001 || o_sel2 !== 1'b1) begin
      errors++; $display("FAIL drain_refill got r=%b v=%b d=%h s=%b expected 010 1 d001 1",
                         last_ready, o_valid2, o_data2, o_sel2);
    end
    cyc(0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b1, "dr_drain");
  endtask

  task automatic test_random();
    int inst;
    logic [2:0] v;
    logic rdy;
    for (int k = 0; k < 400; k++) begin
      inst = (k < 250) ? 1 : 0;
      v = 3'($urandom_range(0, 7));
      rdy = ($urandom_range(0, 3) != 0);
      cyc(inst, v, 16'($urandom), 16'($urandom), 16'($urandom), rdy, "random");
    end
  endtask

  initial begin
    rst = 1'b1; v2 = 2'b00; v3 = 3'b000; rdy2 = 1'b0; rdy3 = 1'b0;
    dat2[0] = 16'h0000; dat2[1] = 16'h0000;
    dat3[0] = 16'h0000; dat3[1] = 16'h0000; dat3[2] = 16'h0000;
    last_ready = 3'b000;
    model_reset();
    test_reset();
    test_single_source();
    test_round_robin();
    test_wrap_idle();
    test_backpressure();
    test_drain_refill();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_arb_np.md
Name: mux_arb_np

Overview:
- Fan-in counterpart of the N-way demultiplexer: merges N independent D-bit source channels into one registered output stream.
- Sources are selected round-robin over valid/ready handshakes.
- Output carries the winning source index, so a downstream demux can route responses back.
- Sits between multiple producers (ALU result, memory read, I/O) and a single shared consumer bus.

Parameters:
- N, 2, number of input channels; legal range 2..16, not required to be a power of two.
- D, 16, bit width of each data word.

Ports:
- i_clk  input  1  single clock; all state updates on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  N  per-channel valid; bit k qualifies i_data[k].
- i_data  input  D x N (unpacked array [N-1:0])  per-channel data word.
- o_ready  output  N  per-channel ready; bit k high means channel k transfers this cycle if i_valid[k].
- o_valid  output  1  output register holds a word.
- o_data  output  D  registered output word.
- o_sel  output  $clog2(N)  index of the channel that supplied o_data.
- i_ready  input  1  downstream accepts o_data this cycle.

Behaviour:
- Reset (async assert, applies immediately): o_valid=0, o_data=0, o_sel=0, round-robin pointer ptr=0. o_ready is all zero while i_rst is high.
- Output register is "free" when o_valid==0, or when o_valid==1 and i_ready==1 (drain and refill in the same cycle).
- Grant (combinational):
  - Search i_valid starting at index ptr, ascending, wrapping from N-1 to 0.
  - The first set bit k wins.
  - If no bit is set, there is no grant.
- o_ready[k] = (k is the grant winner) AND free. At most one o_ready bit is high per cycle.
  - o_ready depends combinationally on i_valid and i_ready. This is the only comb path through the block.
- Transfer on channel k (i_valid[k] && o_ready[k]) at a rising edge:
  - o_data <= i_data[k], o_sel <= k, o_valid <= 1.
  - ptr <= (k==N-1) ? 0 : k+1.
- Drain only (o_valid && i_ready with no input transfer): o_valid <= 0. o_data and o_sel hold their last values.
- Stall (o_valid && !i_ready): o_data, o_sel and ptr hold; o_ready all zero.
- Latency is 1 cycle from accepted input to o_valid.
- Throughput is 1 word/cycle while i_ready stays high.
- ptr advances only on a transfer, never on idle cycles. A lone requester k is therefore served every cycle.
- Non-power-of-two N: ptr and o_sel never exceed N-1. Select codes N..2^W-1 are never produced.
- Source protocol rules:
  - A source holding i_valid high must keep i_data stable until accepted.
  - Dropping i_valid before acceptance is allowed and loses nothing inside the block.
- Reset mid-stall discards the held word. No partial transfer survives reset.
- Deassertion of reset is synchronous to i_clk, handled upstream. The block only requires that the first edge after deassert sees the reset values.

Decomposition:
- Shared package hack_bus_pkg holds:
  - function sel_w(n) returning $clog2(n), used by both demux and mux_arb_np so select widths match.
  - constant MAX_CHANNELS=16.
- Sub-module rr_arbiter_np #(N):
  - Inputs: i_clk, i_rst, i_req[N], i_advance.
  - Outputs: o_grant[N] one-hot, o_grant_idx.
  - Owns ptr and the wrap-around search.
  - mux_arb_np instantiates it and the output register.

Test Plan:
- Reset: assert i_rst mid-run with o_valid=1 -> o_valid, o_data, o_sel go to 0 without waiting for a clock edge; o_ready=0 while reset is held.
- Single source: N=2, D=16, i_valid=01, i_data[0]=16'h1234 for 3 cycles, i_ready=1 -> o_valid high from cycle 1, three words 16'h1234 with o_sel=0 on consecutive cycles; o_ready[1]=0 throughout.
- Round-robin fairness: N=3, all i_valid=1, data k = 16'hA000+k, i_ready=1 -> o_sel sequence 0,1,2,0,1,2; each channel's o_ready is high exactly once per 3 cycles.
- Backpressure: N=2, both valid, i_ready=0 for 4 cycles after the first word -> o_data and o_sel frozen, o_ready=00, ptr unchanged. Releasing i_ready -> next word comes from channel 1, with no word lost or duplicated.
- Wrap and idle: N=3, last grant to channel 2, then idle for 5 cycles, then i_valid=011 -> channel 0 wins (ptr=0 held across idle); next grant goes to channel 1.
- Drain-and-refill: o_valid=1, i_ready=1, i_valid[1]=1 in the same cycle -> o_valid stays 1, o_data updates to channel 1 data next edge, giving back-to-back throughput.
